// File: rtl/seg7_scan_ctrl.sv
// Memory-mapped, time-multiplexed seven-segment controller: DATA/CTRL registers on the CPU bus,
// digit scanning with enable/DP masks, leading-zero suppression, blanking and 16-level PWM.
module seg7_scan_ctrl #(
    parameter int          NUM_DIGITS = 8,
    parameter int          SCAN_DIV   = 20000,
    parameter logic [31:0] BASE_ADDR  = 32'hFFFFF000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           addr,
    input  logic                  we,
    input  logic [31:0]           wdata,
    input  logic                  re,
    output logic [31:0]           rdata,
    output logic [NUM_DIGITS-1:0] dig_en,
    output logic                  DN_A,
    output logic                  DN_B,
    output logic                  DN_C,
    output logic                  DN_D,
    output logic                  DN_E,
    output logic                  DN_F,
    output logic                  DN_G,
    output logic                  DN_DP
);

    localparam int          SEL_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int          CNT_W      = $clog2(SCAN_DIV);
    localparam logic [31:0] CTRL_ADDR  = BASE_ADDR + 32'd4;
    localparam logic [31:0] CTRL_MASK  = 32'h003F_FFFF;
    localparam logic [7:0]  EN_RESET   = 8'((1 << NUM_DIGITS) - 1);
    localparam logic [31:0] CTRL_RESET = {10'd0, 4'hF, 1'b0, 1'b0, 8'h00, EN_RESET};
    localparam logic [31:0] DATA_MASK  = (NUM_DIGITS >= 8) ? 32'hFFFF_FFFF
                                       : 32'((64'd1 << (4 * NUM_DIGITS)) - 64'd1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(NUM_DIGITS - 1);

    logic [31:0]           data_reg;
    logic [31:0]           ctrl_reg;
    logic [CNT_W-1:0]      cnt;
    logic [SEL_W-1:0]      sel;
    logic [3:0]            pwm;
    logic [7:0]            seg_q;

    logic [3:0]            nibble;
    logic [7:0]            dp_mask;
    logic [31:0]           upper_digits;
    logic                  suppressed;
    logic                  lit;
    logic [NUM_DIGITS-1:0] dig_next;
    logic [7:0]            seg_next;

    // Active-low {G..A} pattern of a hex digit (bit 7 of the table entries is the unlit DP).
    function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
        logic [7:0] p;
        case (v)
            4'h0: p = 8'hc0;
            4'h1: p = 8'hf9;
            4'h2: p = 8'ha4;
            4'h3: p = 8'hb0;
            4'h4: p = 8'h99;
            4'h5: p = 8'h92;
            4'h6: p = 8'h82;
            4'h7: p = 8'hf8;
            4'h8: p = 8'h80;
            4'h9: p = 8'h90;
            4'hA: p = 8'h88;
            4'hB: p = 8'h83;
            4'hC: p = 8'hc6;
            4'hD: p = 8'ha1;
            4'hE: p = 8'h86;
            default: p = 8'h8e;
        endcase
        return p[6:0];
    endfunction

    // Bus side: reads sample the register before any same-cycle write lands.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_reg <= '0;
            ctrl_reg <= CTRL_RESET;
            rdata    <= '0;
        end else begin
            if (re && addr == BASE_ADDR) begin
                rdata <= data_reg;
            end else if (re && addr == CTRL_ADDR) begin
                rdata <= ctrl_reg;
            end else begin
                rdata <= '0;
            end
            if (we && addr == BASE_ADDR) begin
                data_reg <= wdata;
            end
            if (we && addr == CTRL_ADDR) begin
                ctrl_reg <= wdata & CTRL_MASK;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            sel <= '0;
            pwm <= '0;
        end else begin
            pwm <= pwm + 4'd1;
            if (cnt == CNT_LAST) begin
                cnt <= '0;
                sel <= (sel == SEL_LAST) ? '0 : sel + SEL_W'(1);
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    // A digit is suppressed when it and every higher displayed nibble are zero.
    always_comb begin
        nibble       = data_reg[{sel, 2'b00} +: 4];
        dp_mask      = ctrl_reg[15:8];
        upper_digits = (data_reg & DATA_MASK) >> {sel, 2'b00};
        suppressed   = ctrl_reg[16] && (sel != '0) && (upper_digits == '0);
        lit          = ctrl_reg[sel] && !ctrl_reg[17] && (pwm <= ctrl_reg[21:18]) && !suppressed;
        dig_next     = '1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            dig_next[i] = !(lit && (sel == SEL_W'(i)));
        end
        seg_next = lit ? {~dp_mask[sel], hex_to_seg(nibble)} : 8'hFF;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dig_en <= '1;
            seg_q  <= 8'hFF;
        end else begin
            dig_en <= dig_next;
            seg_q  <= seg_next;
        end
    end

    assign DN_A  = seg_q[0];
    assign DN_B  = seg_q[1];
    assign DN_C  = seg_q[2];
    assign DN_D  = seg_q[3];
    assign DN_E  = seg_q[4];
    assign DN_F  = seg_q[5];
    assign DN_G  = seg_q[6];
    assign DN_DP = seg_q[7];

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Testbench for seg7_scan_ctrl: scenario tasks compare outputs against a slot/time-based
// reference model of the display and register file.
module tb_seg7_scan_ctrl;

    localparam int          N    = 8;
    localparam int          SD   = 4;
    localparam logic [31:0] BASE = 32'hFFFFF000;

    logic        clk   = 1'b0;
    logic        rst   = 1'b1;
    logic        we    = 1'b0;
    logic        re    = 1'b0;
    logic [31:0] addr  = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic [7:0]  dig_en;
    logic        DN_A, DN_B, DN_C, DN_D, DN_E, DN_F, DN_G, DN_DP;
    logic [7:0]  seg;

    int n_checks = 0;
    int n_fail   = 0;

    int unsigned m_n;
    logic [31:0] m_data;
    logic [31:0] m_ctrl;
    logic [7:0]  exp_dig;
    logic [7:0]  exp_seg;
    logic [31:0] exp_rdata;
    logic [7:0]  hex_tab [16];

    seg7_scan_ctrl #(.NUM_DIGITS(N), .SCAN_DIV(SD), .BASE_ADDR(BASE)) dut (
        .clk(clk), .rst(rst), .addr(addr), .we(we), .wdata(wdata), .re(re), .rdata(rdata),
        .dig_en(dig_en), .DN_A(DN_A), .DN_B(DN_B), .DN_C(DN_C), .DN_D(DN_D), .DN_E(DN_E),
        .DN_F(DN_F), .DN_G(DN_G), .DN_DP(DN_DP)
    );

    assign seg = {DN_DP, DN_G, DN_F, DN_E, DN_D, DN_C, DN_B, DN_A};

    always #5 clk = ~clk;

    // Display seen after k clocks since reset, from the slot/time rules directly.
    function automatic logic [15:0] model_out(input int unsigned k, input logic [31:0] d,
                                              input logic [31:0] c);
        int         slot = int'((k / SD) % N);
        int         phase = int'(k % 16);
        logic [7:0] dig = 8'hFF;
        logic [3:0] nib;
        bit         sup;
        nib = 4'((d >> (4 * slot)) & 32'hF);
        sup = 1'b0;
        if (c[16] && slot != 0) begin
            sup = 1'b1;
            for (int j = slot; j < N; j++) begin
                if (((d >> (4 * j)) & 32'hF) != 0) sup = 1'b0;
            end
        end
        if (c[slot] && !c[17] && phase <= int'(c[21:18]) && !sup) begin
            dig[slot] = 1'b0;
            return {dig, ~c[8 + slot], hex_tab[nib][6:0]};
        end
        return 16'hFFFF;
    endfunction

    task automatic cycle();
        @(posedge clk);
        if (rst) begin
            m_n       = 0;
            m_data    = '0;
            m_ctrl    = 32'h003C_00FF;
            exp_dig   = 8'hFF;
            exp_seg   = 8'hFF;
            exp_rdata = '0;
        end else begin
            {exp_dig, exp_seg} = model_out(m_n, m_data, m_ctrl);
            exp_rdata = '0;
            if (re && addr == BASE) exp_rdata = m_data;
            else if (re && addr == BASE + 32'd4) exp_rdata = m_ctrl;
            if (we && addr == BASE) m_data = wdata;
            if (we && addr == BASE + 32'd4) m_ctrl = {10'd0, wdata[21:0]};
            m_n++;
        end
        #1;
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        we = 1'b1; addr = a; wdata = d;
        cycle();
        we = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] a);
        re = 1'b1; addr = a;
        cycle();
        re = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; we = 1'b1; re = 1'b1; addr = BASE; wdata = $urandom;
        for (int i = 0; i < 3; i++) cycle();
        n_checks++;
        if (dig_en !== 8'hFF || seg !== 8'hFF || rdata !== 32'h0) begin
            n_fail++;
            $display("[TB] FAIL reset_outputs: dig_en=%h seg=%h rdata=%h expected FF FF 0", dig_en, seg, rdata);
        end
        rst = 1'b0; we = 1'b0; re = 1'b0;
        bus_read(BASE);
        n_checks++;
        if (rdata !== 32'h0) begin
            n_fail++;
            $display("[TB] FAIL reset_data: rdata=%h expected 0", rdata);
        end
        bus_read(BASE + 32'd4);
        n_checks++;
        if (rdata !== 32'h003C00FF) begin
            n_fail++;
            $display("[TB] FAIL reset_ctrl: rdata=%h expected 003c00ff", rdata);
        end
    endtask

    task automatic test_first_scan();
        rst = 1'b1; cycle(); rst = 1'b0;
        bus_write(BASE, 32'h12345678);
        cycle();
        n_checks++;
        if (dig_en !== 8'hFE || seg !== 8'h80) begin
            n_fail++;
            $display("[TB] FAIL first_digit0: dig_en=%h seg=%h expected fe 80", dig_en, seg);
        end
        for (int i = 0; i < 3; i++) cycle();
        n_checks++;
        if (dig_en !== 8'hFD || seg !== 8'hf8) begin
            n_fail++;
            $display("[TB] FAIL first_digit1: dig_en=%h seg=%h expected fd f8", dig_en, seg);
        end
        for (int i = 0; i < 64; i++) begin
            cycle();
            n_checks++;
            if (dig_en !== exp_dig || seg !== exp_seg) begin
                n_fail++;
                $display("[TB] FAIL scan: dig_en=%h seg=%h expected %h %h", dig_en, seg, exp_dig, exp_seg);
            end
        end
    endtask

    task automatic test_lzs();
        int bad = 0;
        bus_write(BASE, 32'h00000A05);
        bus_write(BASE + 32'd4, 32'h003D00FF);
        for (int i = 0; i < 40; i++) begin
            cycle();
            n_checks++;
            if (dig_en !== exp_dig || seg !== exp_seg) begin
                n_fail++;
                $display("[TB] FAIL lzs_scan: dig_en=%h seg=%h expected %h %h", dig_en, seg, exp_dig, exp_seg);
            end
            if (dig_en[7:3] !== 5'b11111) bad++;
        end
        n_checks++;
        if (bad !== 0) begin
            n_fail++;
            $display("[TB] FAIL lzs_dark_digits: lit cycles on digits 3..7 = %0d expected 0", bad);
        end
        bus_write(BASE, 32'h0);
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            cycle();
            n_checks++;
            if (dig_en !== exp_dig || seg !== exp_seg) begin
                n_fail++;
                $display("[TB] FAIL lzs_zero: dig_en=%h seg=%h expected %h %h", dig_en, seg, exp_dig, exp_seg);
            end
            if (i > 0 && !(dig_en === 8'hFF || (dig_en === 8'hFE && seg === 8'hc0))) bad++;
        end
        n_checks++;
        if (bad !== 0) begin
            n_fail++;
            $display("[TB] FAIL lzs_only_digit0: bad cycles = %0d expected 0", bad);
        end
    endtask

    task automatic test_masks();
        int bad = 0;
        bus_write(BASE, 32'h9ABCDEF0);
        bus_write(BASE + 32'd4, 32'h003C01FD);
        for (int i = 0; i < 48; i++) begin
            cycle();
            n_checks++;
            if (dig_en !== exp_dig || seg !== exp_seg) begin
                n_fail++;
                $display("[TB] FAIL mask_scan: dig_en=%h seg=%h expected %h %h", dig_en, seg, exp_dig, exp_seg);
            end
            if (i > 0 && (dig_en === 8'hFD || (DN_DP === 1'b0) !== (dig_en === 8'hFE))) bad++;
        end
        n_checks++;
        if (bad !== 0) begin
            n_fail++;
            $display("[TB] FAIL mask_rules: bad cycles = %0d expected 0", bad);
        end
    endtask

    task automatic test_brightness();
        int lit_cnt = 0;
        bus_write(BASE, 32'h87654321);
        bus_write(BASE + 32'd4, 32'h000C00FF);
        for (int i = 0; i < 64; i++) begin
            cycle();
            n_checks++;
            if (dig_en !== exp_dig || seg !== exp_seg) begin
                n_fail++;
                $display("[TB] FAIL bright_scan: dig_en=%h seg=%h expected %h %h", dig_en, seg, exp_dig, exp_seg);
            end
            if (dig_en !== 8'hFF) lit_cnt++;
        end
        n_checks++;
        if (lit_cnt !== 16) begin
            n_fail++;
            $display("[TB] FAIL bright_duty: lit cycles=%0d expected 16", lit_cnt);
        end
        bus_write(BASE + 32'd4, 32'h003E00FF);
        lit_cnt = 0;
        for (int i = 0; i < 32; i++) begin
            cycle();
            if (dig_en !== 8'hFF || seg !== 8'hFF) lit_cnt++;
        end
        n_checks++;
        if (lit_cnt !== 0) begin
            n_fail++;
            $display("[TB] FAIL blank: lit cycles=%0d expected 0", lit_cnt);
        end
    endtask

    task automatic test_readback();
        bus_write(BASE + 32'd4, 32'hFFFFFFFF);
        bus_read(BASE + 32'd4);
        n_checks++;
        if (rdata !== 32'h003FFFFF) begin
            n_fail++;
            $display("[TB] FAIL read_ctrl: rdata=%h expected 003fffff", rdata);
        end
        bus_write(BASE, 32'h11112222);
        we = 1'b1; re = 1'b1; addr = BASE; wdata = 32'hAAAA5555;
        cycle();
        we = 1'b0; re = 1'b0;
        n_checks++;
        if (rdata !== 32'h11112222) begin
            n_fail++;
            $display("[TB] FAIL read_during_write: rdata=%h expected 11112222", rdata);
        end
        bus_read(BASE);
        n_checks++;
        if (rdata !== 32'hAAAA5555) begin
            n_fail++;
            $display("[TB] FAIL read_after_write: rdata=%h expected aaaa5555", rdata);
        end
        bus_read(BASE + 32'd8);
        n_checks++;
        if (rdata !== 32'h0) begin
            n_fail++;
            $display("[TB] FAIL read_unmapped: rdata=%h expected 0", rdata);
        end
        for (int i = 0; i < 80; i++) begin
            we = 1'($urandom); re = 1'($urandom); wdata = $urandom;
            case ($urandom_range(0, 3))
                0: addr = BASE;
                1: addr = BASE + 32'd4;
                2: addr = BASE + 32'd8;
                default: addr = $urandom;
            endcase
            cycle();
            n_checks++;
            if (rdata !== exp_rdata || dig_en !== exp_dig || seg !== exp_seg) begin
                n_fail++;
                $display("[TB] FAIL random_bus: rdata=%h dig_en=%h seg=%h expected %h %h %h", rdata, dig_en, seg, exp_rdata, exp_dig, exp_seg);
            end
        end
        we = 1'b0; re = 1'b0;
    endtask

    task automatic test_reset_mid_scan();
        int guard = 0;
        bus_write(BASE + 32'd4, 32'h003C00FF);
        bus_write(BASE, 32'hFEDCBA98);
        while (!(((m_n / SD) % N) == 5 && (m_n % SD) == 2) && guard < 100) begin
            cycle();
            guard++;
        end
        n_checks++;
        if (guard >= 100) begin
            n_fail++;
            $display("[TB] FAIL midscan_reach_slot5: cycle budget exhausted");
        end
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        n_checks++;
        if (dig_en !== 8'hFF || seg !== 8'hFF) begin
            n_fail++;
            $display("[TB] FAIL midscan_reset: dig_en=%h seg=%h expected ff ff", dig_en, seg);
        end
        cycle();
        n_checks++;
        if (dig_en !== 8'hFE || seg !== 8'hc0) begin
            n_fail++;
            $display("[TB] FAIL midscan_restart: dig_en=%h seg=%h expected fe c0", dig_en, seg);
        end
        for (int i = 0; i < 40; i++) begin
            cycle();
            n_checks++;
            if (dig_en !== exp_dig || seg !== exp_seg) begin
                n_fail++;
                $display("[TB] FAIL midscan_scan: dig_en=%h seg=%h expected %h %h", dig_en, seg, exp_dig, exp_seg);
            end
        end
        bus_read(BASE + 32'd4);
        n_checks++;
        if (rdata !== 32'h003C00FF) begin
            n_fail++;
            $display("[TB] FAIL midscan_ctrl: rdata=%h expected 003c00ff", rdata);
        end
        bus_read(BASE);
        n_checks++;
        if (rdata !== 32'h0) begin
            n_fail++;
            $display("[TB] FAIL midscan_data: rdata=%h expected 0", rdata);
        end
    endtask

    task automatic test_random_display();
        for (int r = 0; r < 12; r++) begin
            bus_write(BASE, $urandom >> (4 * $urandom_range(0, 8)));
            bus_write(BASE + 32'd4, $urandom);
            for (int i = 0; i < 40; i++) begin
                cycle();
                n_checks++;
                if (dig_en !== exp_dig || seg !== exp_seg) begin
                    n_fail++;
                    $display("[TB] FAIL random_display: dig_en=%h seg=%h expected %h %h", dig_en, seg, exp_dig, exp_seg);
                end
            end
        end
    endtask

    initial begin
        hex_tab = '{8'hc0, 8'hf9, 8'ha4, 8'hb0, 8'h99, 8'h92, 8'h82, 8'hf8,
                    8'h80, 8'h90, 8'h88, 8'h83, 8'hc6, 8'ha1, 8'h86, 8'h8e};
        test_reset();
        test_first_scan();
        test_lzs();
        test_masks();
        test_brightness();
        test_readback();
        test_reset_mid_scan();
        test_random_display();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
